reg_ctrl_seq: RTL

//  Drives the synchronous control pins (D/CE/SCLR/SSET/SINIT) of a downstream
//  C_REG_FD-style register bank. Accepts commands over a valid/ready handshake
//  and turns each into timed bursts of control pulses. Keeps a shadow copy of
//  the target Q for readback, so host logic never has to sample the register.

---
 rtl/reg_ctrl_pkg.sv | 41 ++++
 rtl/reg_ctrl_cnt.sv | 26 ++
 rtl/reg_ctrl_seq.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/reg_ctrl_pkg.sv
// Shared op codes, FSM states and the target-register update rule for reg_ctrl_seq.
package reg_ctrl_pkg;

  localparam int unsigned SHADOW_MAXW = 64;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_CLEAR = 3'd2,
    OP_SET   = 3'd3,
    OP_INIT  = 3'd4,
    OP_HOLD  = 3'd5,
    OP_ILL6  = 3'd6,
    OP_ILL7  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    SETTLE
  } state_e;

  // Callers pass zero-extended values and truncate the result to their own width.
  function automatic logic [SHADOW_MAXW-1:0] shadow_next(
    input logic [SHADOW_MAXW-1:0] q,
    input logic                   ce,
    input logic                   sclr,
    input logic                   sset,
    input logic                   sinit,
    input logic [SHADOW_MAXW-1:0] d,
    input logic [SHADOW_MAXW-1:0] siv,
    input logic                   prio
  );
    if (sclr && (prio || !sset)) return '0;
    if (sset)  return '1;
    if (sinit) return siv;
    if (ce)    return d;
    return q;
  endfunction

endpackage

// File: rtl/reg_ctrl_cnt.sv
// Loadable down-counter holding at zero, with terminal-count flag.
module reg_ctrl_cnt #(
  parameter int unsigned C_CNT_WIDTH = 8
) (
  input  logic                   CLK,
  input  logic                   ACLR_N,
  input  logic                   load,
  input  logic                   dec,
  input  logic [C_CNT_WIDTH-1:0] load_val,
  output logic [C_CNT_WIDTH-1:0] cnt,
  output logic                   tc
);

  always_ff @(posedge CLK or negedge ACLR_N) begin
    if (!ACLR_N) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - C_CNT_WIDTH'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/reg_ctrl_seq.sv
// Command sequencer driving the sync control pins of a C_REG_FD-style register, with shadow Q.
// Optional ABORT input enabled by defining REG_CTRL_SEQ_ABORT_EN.
module reg_ctrl_seq
  import reg_ctrl_pkg::*;
#(
  parameter int unsigned         C_WIDTH         = 16,
  parameter logic [C_WIDTH-1:0]  C_SINIT_VAL     = '0,
  parameter int unsigned         C_SYNC_PRIORITY = 1,
  parameter int unsigned         C_SYNC_ENABLE   = 0,
  parameter int unsigned         C_CNT_WIDTH     = 8
) (
  input  logic                   CLK,
  input  logic                   ACLR_N,
`ifdef REG_CTRL_SEQ_ABORT_EN
  input  logic                   ABORT,
`endif
  input  logic                   CMD_VALID,
  output logic                   CMD_READY,
  input  logic [2:0]             CMD_OP,
  input  logic [C_WIDTH-1:0]     CMD_DATA,
  input  logic [C_CNT_WIDTH-1:0] CMD_LEN,
  output logic [C_WIDTH-1:0]     D,
  output logic                   CE,
  output logic                   SCLR,
  output logic                   SSET,
  output logic                   SINIT,
  output logic [C_WIDTH-1:0]     SHADOW_Q,
  output logic                   SHADOW_VLD,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   ERR
);

  localparam logic SYNC_CE = (C_SYNC_ENABLE != 0);
  localparam logic PRIO    = (C_SYNC_PRIORITY != 0);

  state_e               state;
  op_e                  cmd_op;
  logic [C_WIDTH-1:0]   d_q, shadow_q, shadow_nx;
  logic                 ce_q, sclr_q, sset_q, sinit_q, done_q, err_q, vld_q;
  logic                 abort_w, cnt_tc, any_ctrl;
  logic [C_CNT_WIDTH-1:0] cnt;

`ifdef REG_CTRL_SEQ_ABORT_EN
  assign abort_w = ABORT;
`else
  assign abort_w = 1'b0;
`endif

  assign cmd_op = op_e'(CMD_OP);

  reg_ctrl_cnt #(.C_CNT_WIDTH(C_CNT_WIDTH)) u_cnt (
    .CLK      (CLK),
    .ACLR_N   (ACLR_N),
    .load     ((state == IDLE) && CMD_VALID),
    .dec      (state == ACTIVE),
    .load_val (CMD_LEN),
    .cnt      (cnt),
    .tc       (cnt_tc)
  );

  always_ff @(posedge CLK or negedge ACLR_N) begin
    if (!ACLR_N) begin
      state   <= IDLE;
      d_q     <= '0;
      ce_q    <= 1'b0;
      sclr_q  <= 1'b0;
      sset_q  <= 1'b0;
      sinit_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (CMD_VALID) begin
            state <= ACTIVE;
            unique case (cmd_op)
              OP_LOAD: begin
                ce_q <= 1'b1;
                d_q  <= CMD_DATA;
              end
              OP_CLEAR: begin
                sclr_q <= 1'b1;
                ce_q   <= SYNC_CE;
              end
              OP_SET: begin
                sset_q <= 1'b1;
                ce_q   <= SYNC_CE;
              end
              OP_INIT: begin
                sinit_q <= 1'b1;
                ce_q    <= SYNC_CE;
              end
              OP_HOLD: ;
              OP_NOP: begin
                state  <= SETTLE;
                done_q <= 1'b1;
              end
              default: begin
                state  <= SETTLE;
                done_q <= 1'b1;
                err_q  <= 1'b1;
              end
            endcase
          end
        end
        // Counter reaches zero on the edge that issues the last burst cycle.
        ACTIVE: begin
          if (abort_w || cnt_tc) begin
            state   <= SETTLE;
            d_q     <= '0;
            ce_q    <= 1'b0;
            sclr_q  <= 1'b0;
            sset_q  <= 1'b0;
            sinit_q <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= abort_w;
          end
        end
        SETTLE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // With C_SYNC_ENABLE=1 the target ignores sync controls unless CE is also high.
  assign any_ctrl  = ce_q | sclr_q | sset_q | sinit_q;
  assign shadow_nx = C_WIDTH'(shadow_next(
                       SHADOW_MAXW'(shadow_q),
                       ce_q,
                       sclr_q  & (ce_q | ~SYNC_CE),
                       sset_q  & (ce_q | ~SYNC_CE),
                       sinit_q & (ce_q | ~SYNC_CE),
                       SHADOW_MAXW'(d_q),
                       SHADOW_MAXW'(C_SINIT_VAL),
                       PRIO));

  always_ff @(posedge CLK or negedge ACLR_N) begin
    if (!ACLR_N) begin
      shadow_q <= '0;
      vld_q    <= 1'b0;
    end else if (any_ctrl) begin
      shadow_q <= shadow_nx;
      vld_q    <= 1'b1;
    end
  end

  assign CMD_READY  = (state == IDLE) && ACLR_N;
  assign BUSY       = (state != IDLE);
  assign D          = d_q;
  assign CE         = ce_q;
  assign SCLR       = sclr_q;
  assign SSET       = sset_q;
  assign SINIT      = sinit_q;
  assign DONE       = done_q;
  assign ERR        = err_q;
  assign SHADOW_Q   = shadow_q;
  assign SHADOW_VLD = vld_q;

endmodule
